// File: rtl/fpu_pkg.sv
// Shared FP-datapath definitions: default widths, a constant-foldable clog2 and
// the bundle of normalisation results handed to the exponent-adjust stage.
package fpu_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int WIDTH_DEF = 27;
  localparam int OUT_W_DEF = 24;
  localparam int SHW_DEF   = clog2(WIDTH_DEF);

  typedef struct packed {
    logic [OUT_W_DEF-1:0] mant;
    logic [SHW_DEF-1:0]   shift;
    logic                 sticky;
    logic                 corr;
    logic                 zero;
  } norm_out_t;

endpackage

// File: rtl/lza_lod_enc.sv
// Leading-one priority encoder: converts the LZA indicator string into the
// coarse left-shift amount. An all-zero string yields the maximum shift.
module lza_lod_enc
  import fpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] f,
  output logic [SHW-1:0]   shl
);

  // Ascending scan: the highest set bit is the last to write, so it wins
  always_comb begin
    shl = SHW'(WIDTH - 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (f[i]) shl = SHW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/lza_norm_pipe.sv
// Four-stage normalisation pipeline for the FP adder: LZA predict, leading-one
// encode, coarse barrel shift, then 1-bit correction with sticky/zero flags.
// All stages advance together and stall together under output backpressure.
module lza_norm_pipe
  import fpu_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  OUT_W = OUT_W_DEF,
  localparam int SHW   = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] norm_mant,
  output logic [SHW-1:0]   shift_amt,
  output logic             sticky,
  output logic             lza_corr,
  output logic             zero
);

  // Bits of the final shifted value that fall below the kept mantissa
  localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << (WIDTH - OUT_W));

  logic             en;
  logic [WIDTH-1:0] t_c, z_c, f_c;
  logic [SHW-1:0]   shl_c;
  logic             corr_c;
  logic [WIDTH-1:0] fin_c;
  logic [SHW-1:0]   shamt_c;

  logic             vld_p1, vld_p2, vld_p3;
  logic [WIDTH-1:0] f_p1, sum_p1, sum_p2, sh_p3;
  logic [SHW-1:0]   shl_p2, shl_p3;
  logic             zero_p2, zero_p3;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage 1 predictor: leading one of f marks the predicted MSB of sum (exact or one high)
  always_comb begin
    t_c = a ^ b;
    z_c = ~a & ~b;
    f_c = t_c ^ ~{z_c[WIDTH-2:0], 1'b0};
  end

  // ---- stage 1 boundary: indicator string and sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      f_p1   <= '0;
      sum_p1 <= '0;
    end else if (en) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        f_p1   <= f_c;
        sum_p1 <= sum;
      end
    end
  end

  lza_lod_enc #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_lod (
    .f   (f_p1),
    .shl (shl_c)
  );

  // ---- stage 2 boundary: coarse shift amount, sum, zero detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      shl_p2  <= '0;
      sum_p2  <= '0;
      zero_p2 <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        shl_p2  <= shl_c;
        sum_p2  <= sum_p1;
        zero_p2 <= (sum_p1 == '0);
      end
    end
  end

  // ---- stage 3 boundary: coarse-shifted sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      sh_p3   <= '0;
      shl_p3  <= '0;
      zero_p3 <= 1'b0;
    end else if (en) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        sh_p3   <= sum_p2 << shl_p2;
        shl_p3  <= shl_p2;
        zero_p3 <= zero_p2;
      end
    end
  end

  // Correction: one more shift when the prediction fell one position short
  always_comb begin
    corr_c  = ~sh_p3[WIDTH-1] & ~zero_p3 & (shl_p3 < SHW'(WIDTH - 1));
    fin_c   = corr_c ? {sh_p3[WIDTH-2:0], 1'b0} : sh_p3;
    shamt_c = shl_p3 + {{(SHW-1){1'b0}}, corr_c};
  end

  // ---- stage 4 boundary: registered outputs, zero result forces all fields to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      norm_mant <= '0;
      shift_amt <= '0;
      sticky    <= 1'b0;
      lza_corr  <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p3;
      if (vld_p3) begin
        norm_mant <= zero_p3 ? '0 : fin_c[WIDTH-1 -: OUT_W];
        shift_amt <= zero_p3 ? '0 : shamt_c;
        sticky    <= ~zero_p3 & (|(fin_c & LOW_MASK));
        lza_corr  <= corr_c;
        zero      <= zero_p3;
      end
    end
  end

endmodule
